// File: rtl/ws2812_tx.sv
// WS2812/SK6812 serial bit encoder: valid/ready pixel words out as NRZ pulse pairs with latch hold.
// Define WS2812_RGBW_EN for 32-bit RGBW words; the default build sends 24-bit GRB.
module ws2812_tx #(
    parameter int T0H_CNT = 20,
    parameter int T1H_CNT = 40,
    parameter int BIT_CNT = 62,
    parameter int RST_CNT = 15000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] in_data_i,
    input  logic        in_last_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic        dout_o,
    output logic        busy_o
);

    localparam int MAX_CNT = (BIT_CNT > RST_CNT) ? BIT_CNT : RST_CNT;
    localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
`ifdef WS2812_RGBW_EN
    localparam int NBITS = 32;
`else
    localparam int NBITS = 24;
`endif
    localparam int IW = $clog2(NBITS);

    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CNT - 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CNT - 1);
    localparam logic [CW-1:0] T0H      = CW'(T0H_CNT);
    localparam logic [CW-1:0] T1H      = CW'(T1H_CNT);
    localparam logic [IW-1:0] IDX_TOP  = IW'(NBITS - 1);

    typedef enum logic [1:0] {
        S_LATCH,
        S_IDLE,
        S_BIT
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NBITS-1:0] shift_q, shift_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             last_q, last_d;
    logic             dout_q;
    logic [NBITS-1:0] load_word;
    logic             bit_end;
    logic             xfer;
    logic [CW-1:0]    th;

`ifdef WS2812_RGBW_EN
    assign load_word = in_data_i;
`else
    logic unused_data_hi;
    assign load_word      = in_data_i[NBITS-1:0];
    assign unused_data_hi = ^in_data_i[31:NBITS];
`endif

    assign bit_end    = (state_q == S_BIT) && (cnt_q == BIT_LAST);
    // Ready during the final cycle of a non-last word lets the next pixel follow with no gap.
    assign in_ready_o = (state_q == S_IDLE) || (bit_end && (idx_q == '0) && !last_q);
    assign xfer       = in_valid_i && in_ready_o;
    assign th         = shift_q[NBITS-1] ? T1H : T0H;
    assign busy_o     = (state_q != S_IDLE);
    assign dout_o     = dout_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        shift_d = shift_q;
        idx_d   = idx_q;
        last_d  = last_q;
        case (state_q)
            S_LATCH: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            S_IDLE: begin
                cnt_d = '0;
            end
            S_BIT: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q != '0) begin
                        idx_d   = idx_q - IW'(1);
                        shift_d = {shift_q[NBITS-2:0], 1'b0};
                    end else if (last_q) begin
                        state_d = S_LATCH;
                    end else begin
                        // Underrun within a frame: wait in IDLE without latching.
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_LATCH;
                cnt_d   = '0;
            end
        endcase
        if (xfer) begin
            state_d = S_BIT;
            cnt_d   = '0;
            shift_d = load_word;
            idx_d   = IDX_TOP;
            last_d  = in_last_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_LATCH;
            cnt_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            dout_q  <= (state_q == S_BIT) && (cnt_q < th);
        end
    end

endmodule

// File: doc/ws2812_tx.md
# ws2812_tx

Serial bit encoder for WS2812/SK6812 pixel chains. It runs in the system clock domain and is reset by the synchronized reset released by the reset synchronizer. Pixel words arrive over a valid/ready handshake. Each word is shifted out MSB-first as NRZ high/low pulse pairs on a single data line. After the last pixel of a frame, the line is held low for the latch (reset) period.

## Interface
Parameters:
- T0H_CNT, default 20: high-time cycles for a '0' bit (0.4 µs at 50 MHz).
- T1H_CNT, default 40: high-time cycles for a '1' bit (0.8 µs).
- BIT_CNT, default 62: total cycles per bit (1.25 µs). Requires 1 ≤ T0H_CNT < T1H_CNT < BIT_CNT.
- RST_CNT, default 15000: low cycles for latch/reset (300 µs).

Ports:
- clk_i, in, 1: system clock, rising edge.
- rst_i, in, 1: reset, synchronous, active-high.
- in_data_i, in, 32: pixel word. Bits [23:0] are GRB; bits [31:24] are used only with the RGBW option.
- in_last_i, in, 1: the word is the last pixel of a frame. Sampled together with in_data_i.
- in_valid_i, in, 1: in_data_i/in_last_i are valid.
- in_ready_o, out, 1: the block accepts a word this cycle.
- dout_o, out, 1: registered serial line to the LED chain.
- busy_o, out, 1: the block is not in IDLE.

## Operation
- NBITS is 24, or 32 with WS2812_RGBW_EN. Transmission is MSB-first: bit 23 (or bit 31) goes first.
- States:
  - LATCH: dout_o=0. cnt counts 0..RST_CNT-1, then the block goes to IDLE.
  - IDLE: in_ready_o=1, dout_o=0.
  - BIT: dout_o=1 while cnt < TH, else 0. TH=T1H_CNT if the current bit is 1, else T0H_CNT. cnt counts 0..BIT_CNT-1.
- Transfer occurs when in_valid_i && in_ready_o on a rising edge. On transfer:
  - shift register ← in_data_i,
  - last_q ← in_last_i,
  - bit_idx ← NBITS-1,
  - cnt ← 0,
  - state ← BIT.
- At the end of a bit (cnt==BIT_CNT-1):
  - If bit_idx>0: decrement bit_idx, shift, cnt ← 0.
  - If bit_idx==0 and last_q=1: go to LATCH with cnt ← 0. in_ready_o=0.
  - If bit_idx==0 and last_q=0: in_ready_o=1 in this same cycle.
    - On transfer, the next word starts with no gap.
    - Otherwise the block goes to IDLE (underrun).
- An underrun inside a frame does not latch. The upstream block must refill within the chain's latch threshold (about 5 µs for WS2812) or the LEDs will latch early. This is the upstream block's responsibility.
- The counter is $clog2(max(BIT_CNT,RST_CNT)) bits wide and holds no saturation state. Contents of in_data_i are don't-care when in_valid_i=0.

## Timing
- Reset values (cycle after rst_i sampled high): state=LATCH, cnt=0, dout_o=0, in_ready_o=0, busy_o=1.
- Power-up: in_ready_o first rises exactly RST_CNT cycles after the first cycle with rst_i=0. This guarantees a latch before the first pixel.
- Latency: with a transfer at edge N, dout_o=1 from edge N+1.
- Each bit lasts exactly BIT_CNT cycles. A pixel lasts NBITS·BIT_CNT cycles. Back-to-back pixels are contiguous.
- Sequence after a last pixel: last bit ends, then RST_CNT cycles of dout_o=0, then in_ready_o=1.
- Reset mid-operation: on the edge where rst_i=1, the block forces the reset values. In-flight data is discarded, and the full RST_CNT latch repeats after release.
- in_ready_o is a combinational decode of state/cnt/bit_idx/last_q only. It never depends on in_valid_i.
- in_valid_i may be held while in_ready_o=0. Words are accepted only on handshake.
- busy_o=0 only in IDLE.

## Configuration
- WS2812_RGBW_EN:
  - Defined: NBITS=32 and all of in_data_i[31:0] is sent (SK6812 RGBW, W channel last).
  - Undefined: NBITS=24. in_data_i[31:24] is ignored, and the shift register and bit index are sized for 24.

## Test plan
Bench parameters: T0H_CNT=2, T1H_CNT=4, BIT_CNT=6, RST_CNT=10.
- Reset: hold rst_i=1 for 3 cycles → dout_o=0, in_ready_o=0, busy_o=1. After release, in_ready_o=1 exactly 10 cycles later.
- Single pixel 0xA50000 with last=1 → bit 23 gives 4 high + 2 low, bit 22 gives 2 high + 4 low, and so on for 144 cycles. Then 10 low cycles, then in_ready_o=1.
- Back-to-back: pixels 0xFFFFFF (last=0) and 0x000000 (last=1) with valid held → first is 24× (4H/2L). The second's first rising edge is exactly 144 cycles after the first's, with no gap. The latch follows the second.
- Underrun: pixel 0x800000 (last=0), valid deasserted → IDLE, dout_o=0, in_ready_o=1, no latch. A later pixel with last=1 transmits, then latches.
- Mid-frame reset: rst_i=1 for 1 cycle during bit 10 → dout_o=0 next cycle. After release, in_ready_o=0 for 10 cycles. The remaining bits are never emitted.
- With WS2812_RGBW_EN: word 0x000000FF, last=1 → 32 bit periods (192 cycles). The final 8 bits are '1' pulses (4H/2L), then the latch. Without the macro, the same word sends 24 bits: 16 '0' then 8 '1'.
